// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a single asynchronous-strobe memory unit.
// Define MEM_ARB_LOCK_EN to add LOCK0/LOCK1 inputs that let an owner keep the port across transfers.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic                  WE0,
  input  logic                  WE1,
  input  logic [ADDR_WIDTH-1:0] ADDR0,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  input  logic [DATA_WIDTH-1:0] WDATA0,
  input  logic [DATA_WIDTH-1:0] WDATA1,
`ifdef MEM_ARB_LOCK_EN
  input  logic                  LOCK0,
  input  logic                  LOCK1,
`endif
  input  logic [DATA_WIDTH-1:0] MEM_RDATA,
  output logic                  GNT0,
  output logic                  GNT1,
  output logic                  DONE0,
  output logic                  DONE1,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  MEM_CS,
  output logic                  MEM_RD_N,
  output logic                  MEM_WR_N,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_WDATA,
  output logic                  MEM_WDATA_OE
);

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, RECOVER} state_t;

  state_t                state;
  state_t                next_state;
  logic                  owner;
  logic                  last;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  win;
`ifdef MEM_ARB_LOCK_EN
  logic                  lock_flag;
  logic                  lock_hold;
`endif

  // Winner of the IDLE arbitration; on a tie the requester that did not go last wins.
  always_comb begin
    win = ~last;
    if (REQ0 && !REQ1) win = 1'b0;
    else if (REQ1 && !REQ0) win = 1'b1;
`ifdef MEM_ARB_LOCK_EN
    lock_hold = lock_flag && (last ? REQ1 : REQ0);
    if (lock_hold) win = last;
`endif
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state   = state;
    GNT0         = 1'b0;
    GNT1         = 1'b0;
    DONE0        = 1'b0;
    DONE1        = 1'b0;
    MEM_CS       = 1'b0;
    MEM_RD_N     = 1'b1;
    MEM_WR_N     = 1'b1;
    MEM_ADDR     = '0;
    MEM_WDATA    = '0;
    MEM_WDATA_OE = 1'b0;
    case (state)
      IDLE: begin
        if (REQ0 || REQ1) next_state = ISSUE;
      end
      ISSUE: begin
        next_state   = XFER;
        GNT0         = ~owner;
        GNT1         = owner;
        MEM_CS       = 1'b1;
        MEM_RD_N     = we_q;
        MEM_WR_N     = ~we_q;
        MEM_ADDR     = addr_q;
        MEM_WDATA_OE = we_q;
        MEM_WDATA    = we_q ? wdata_q : '0;
      end
      XFER: begin
        next_state   = RECOVER;
        GNT0         = ~owner;
        GNT1         = owner;
        MEM_ADDR     = addr_q;
        MEM_WDATA_OE = we_q;
        MEM_WDATA    = we_q ? wdata_q : '0;
      end
      RECOVER: begin
        next_state = IDLE;
        GNT0       = ~owner;
        GNT1       = owner;
        DONE0      = ~owner;
        DONE1      = owner;
        MEM_ADDR   = addr_q;
      end
      default: next_state = IDLE;
    endcase
  end

  // Transfer context is latched at arbitration so requesters may change inputs once DONE is seen.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      owner     <= 1'b0;
      last      <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
`ifdef MEM_ARB_LOCK_EN
      lock_flag <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (REQ0 || REQ1) begin
            owner   <= win;
            we_q    <= win ? WE1 : WE0;
            addr_q  <= win ? ADDR1 : ADDR0;
            wdata_q <= win ? WDATA1 : WDATA0;
          end
`ifdef MEM_ARB_LOCK_EN
          if (!lock_hold) lock_flag <= 1'b0;
`endif
        end
        XFER: begin
          if (!we_q) rdata_q <= MEM_RDATA;
        end
        RECOVER: begin
          last <= owner;
`ifdef MEM_ARB_LOCK_EN
          lock_flag <= owner ? LOCK1 : LOCK0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign RDATA = rdata_q;

endmodule
